// File: rtl/eeprom_spi_reader.sv
// eeprom_spi_reader
// -----------------
// Reads a serial EEPROM image from byte 0 up to byte LAST_ADR. It sends the
// READ command (03h) and a 16-bit zero address in SPI mode 0, then streams
// bytes back continuously. Each received byte is presented on DATA, with the
// previous byte on DATA_DFF and its index on ADR, and is qualified by a
// one-cycle EN strobe.
//
// Ports
//   clk       system clock, all flops on the rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle request to read the image; ignored while busy
//   busy      high from the cycle after start is accepted until the cycle after done
//   done      one-cycle pulse, coincident with spi_cs_n rising
//   spi_cs_n  EEPROM chip select, active low
//   spi_sck   SPI clock, idle low, half-period CLK_DIV clk cycles
//   spi_mosi  command/address out, MSB first
//   spi_miso  data in, MSB first
//   EN        one-cycle strobe: DATA/DATA_DFF/ADR valid
//   DATA      most recent received byte
//   DATA_DFF  byte received immediately before DATA
//   ADR       byte index of DATA
module eeprom_spi_reader #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [14:0] LAST_ADR = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        EN,
  output logic [7:0]  DATA,
  output logic [7:0]  DATA_DFF,
  output logic [14:0] ADR
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, FINISH} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [23:0] CMD_ADDR = {8'h03, 16'h0000};

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [23:0] tx_q, tx_d;
  logic [6:0]  rx_q, rx_d;
  logic [14:0] idx_q, idx_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        done_q, done_d;
  logic        en_q, en_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  dff_q, dff_d;
  logic [14:0] adr_q, adr_d;

  // tick marks the last cycle of an SCK half-period; the SCK edge it
  // produces appears on the following clk edge.
  logic tick, rise, fall;
  assign tick = (div_q == DIV_LAST);
  assign rise = tick & ~sck_q;
  assign fall = tick & sck_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      idx_q   <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      dff_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
      done_q  <= done_d;
      en_q    <= en_d;
      data_q  <= data_d;
      dff_q   <= dff_d;
      adr_q   <= adr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    data_d  = data_q;
    dff_d   = dff_q;
    adr_d   = adr_q;
    // The divider free-runs for the whole transfer so SCK timing stays
    // continuous across the CMD/ADDR/READ/FINISH boundaries.
    if (state_q == IDLE || tick) div_d = '0;
    else                         div_d = div_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CMD;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          tx_d    = CMD_ADDR;   // first MOSI bit valid from the first CMD cycle
          rx_d    = '0;
          bit_d   = '0;
          idx_d   = '0;
          data_d  = '0;
          dff_d   = '0;
          adr_d   = '0;
        end
      end
      CMD, ADDR: begin
        if (tick) sck_d = ~sck_q;
        // MOSI advances together with the falling SCK edge.
        if (fall) begin
          tx_d = {tx_q[22:0], 1'b0};
          if ((state_q == CMD && bit_q == 4'd7) || bit_q == 4'd15) begin
            bit_d   = '0;
            state_d = (state_q == CMD) ? ADDR : READ;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      READ: begin
        if (tick) sck_d = ~sck_q;
        if (rise) begin
          rx_d = {rx_q[5:0], spi_miso};
          if (bit_q == 4'd7) begin
            bit_d  = '0;
            en_d   = 1'b1;
            data_d = {rx_q, spi_miso};
            dff_d  = data_q;
            adr_d  = idx_q;
            if (idx_q != LAST_ADR) idx_d = idx_q + 15'd1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
        // Leave READ only after the final strobe so EN stays inside READ.
        if (en_q && adr_q == LAST_ADR) state_d = FINISH;
      end
      FINISH: begin
        if (done_q)                 state_d = IDLE;
        else if (fall)              sck_d   = 1'b0;
        else if (tick && !cs_n_q) begin
          cs_n_d = 1'b1;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = tx_q[23];
  assign EN       = en_q;
  assign DATA     = data_q;
  assign DATA_DFF = dff_q;
  assign ADR      = adr_q;

endmodule

// File: tb/tb_eeprom_spi_reader.sv
// Self-checking bench for eeprom_spi_reader. Two instances: A (CLK_DIV=2,
// LAST_ADR=3) and B (CLK_DIV=4, LAST_ADR=0), each talking to a behavioural
// EEPROM that answers the READ command from a byte array.
module tb_eeprom_spi_reader;
  localparam int DA = 2;
  localparam int LA = 3;
  localparam int DB = 4;
  localparam int LB = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A ----------------
  logic a_start, a_busy, a_done, a_cs_n, a_sck, a_mosi, a_en;
  logic a_miso = 1'b0;
  logic [7:0] a_data, a_dff;
  logic [14:0] a_adr;
  eeprom_spi_reader #(.CLK_DIV(DA), .LAST_ADR(15'(LA))) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .spi_cs_n(a_cs_n), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso),
    .EN(a_en), .DATA(a_data), .DATA_DFF(a_dff), .ADR(a_adr));

  // ---------------- instance B ----------------
  logic b_start, b_busy, b_done, b_cs_n, b_sck, b_mosi, b_en;
  logic b_miso = 1'b0;
  logic [7:0] b_data, b_dff;
  logic [14:0] b_adr;
  eeprom_spi_reader #(.CLK_DIV(DB), .LAST_ADR(15'(LB))) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .spi_cs_n(b_cs_n), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso),
    .EN(b_en), .DATA(b_data), .DATA_DFF(b_dff), .ADR(b_adr));

  // ---------------- EEPROM models (mode 0) ----------------
  logic [7:0]  a_mem [0:3];
  logic [7:0]  b_byte;
  int          a_rise = 0, b_rise = 0, a_k, b_k;
  logic [23:0] a_cmd = '0, b_cmd = '0;

  always @(negedge a_cs_n or posedge a_sck) begin
    if (a_sck === 1'b0) begin a_rise = 0; a_cmd = '0; end
    else if (a_cs_n === 1'b0) begin
      if (a_rise < 24) a_cmd = {a_cmd[22:0], a_mosi};
      a_rise++;
    end
  end
  always @(negedge a_sck) if (a_cs_n === 1'b0 && a_rise >= 24) begin
    a_k = a_rise - 24;
    a_miso = (a_k / 8 < 4) ? a_mem[a_k/8][7 - a_k%8] : 1'b0;
  end

  always @(negedge b_cs_n or posedge b_sck) begin
    if (b_sck === 1'b0) begin b_rise = 0; b_cmd = '0; end
    else if (b_cs_n === 1'b0) begin
      if (b_rise < 24) b_cmd = {b_cmd[22:0], b_mosi};
      b_rise++;
    end
  end
  always @(negedge b_sck) if (b_cs_n === 1'b0 && b_rise >= 24) begin
    b_k = b_rise - 24;
    b_miso = (b_k < 8) ? b_byte[7 - b_k] : 1'b0;
  end

  // ---------------- monitors (sample on falling clk) ----------------
  int          a_en_cyc[$], b_en_cyc[$];
  logic [7:0]  a_en_data[$], a_en_dff[$], b_en_data[$], b_en_dff[$];
  logic [14:0] a_en_adr[$], b_en_adr[$];
  int a_done_cnt = 0, a_done_cyc = 0, b_done_cnt = 0, b_done_cyc = 0;
  logic b_prev_sck = 1'b0, b_prev_mosi = 1'b0, b_prev_cs = 1'b1;
  int   b_run = 0, b_runs[$], b_mosi_bad = 0, b_cs_bad = 0;

  always @(negedge clk) begin
    if (a_en === 1'b1) begin
      a_en_cyc.push_back(cyc); a_en_adr.push_back(a_adr);
      a_en_data.push_back(a_data); a_en_dff.push_back(a_dff);
    end
    if (a_done === 1'b1) begin a_done_cnt++; a_done_cyc = cyc; end
    if (b_en === 1'b1) begin
      b_en_cyc.push_back(cyc); b_en_adr.push_back(b_adr);
      b_en_data.push_back(b_data); b_en_dff.push_back(b_dff);
    end
    if (b_done === 1'b1) begin b_done_cnt++; b_done_cyc = cyc; end
    // SCK run lengths and MOSI/CS stability for instance B
    if (b_cs_n === 1'b0) begin
      if (b_prev_cs === 1'b0 && b_sck === b_prev_sck) b_run++;
      else begin
        if (b_prev_cs === 1'b0) b_runs.push_back(b_run);
        b_run = 1;
      end
      if (b_mosi !== b_prev_mosi && b_sck !== 1'b0) b_mosi_bad++;
    end else if (b_prev_cs === 1'b0) b_runs.push_back(b_run);
    if (b_cs_n !== b_prev_cs && b_sck !== 1'b0) b_cs_bad++;
    b_prev_sck = b_sck; b_prev_mosi = b_mosi; b_prev_cs = b_cs_n;
  end

  // ---------------- stimulus helpers ----------------
  task automatic a_start_pulse(output int acc);
    @(negedge clk); a_start = 1'b1;
    @(posedge clk); #1; acc = cyc; a_start = 1'b0;
  endtask
  task automatic a_wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin @(negedge clk); #1; if (a_done_cnt != d0) ok = 1'b1; end
  endtask
  task automatic b_start_pulse(output int acc);
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1; acc = cyc; b_start = 1'b0;
  endtask
  task automatic b_wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin @(negedge clk); #1; if (b_done_cnt != d0) ok = 1'b1; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({a_cs_n, a_sck, a_mosi, a_en, a_busy, a_done} !== 6'b100000) begin
      n_err++; $display("FAIL reset_a_ctrl: got %b expected 100000", {a_cs_n, a_sck, a_mosi, a_en, a_busy, a_done}); end
    n_cmp++; if ({a_data, a_dff, a_adr} !== 31'd0) begin
      n_err++; $display("FAIL reset_a_data: got %h expected 0", {a_data, a_dff, a_adr}); end
    n_cmp++; if ({b_cs_n, b_sck, b_mosi, b_en, b_busy, b_done} !== 6'b100000) begin
      n_err++; $display("FAIL reset_b_ctrl: got %b expected 100000", {b_cs_n, b_sck, b_mosi, b_en, b_busy, b_done}); end
    n_cmp++; if ({b_data, b_dff, b_adr} !== 31'd0) begin
      n_err++; $display("FAIL reset_b_data: got %h expected 0", {b_data, b_dff, b_adr}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({a_cs_n, a_busy, b_cs_n, b_busy} !== 4'b1010) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 1010", {a_cs_n, a_busy, b_cs_n, b_busy}); end
  endtask

  task automatic test_read_pattern();
    int acc, d0, base; bit ok; logic [7:0] exp_dff;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin a_mem[0] = 8'hAA; a_mem[1] = 8'h55; a_mem[2] = 8'h12; a_mem[3] = 8'h34; end
      else for (int j = 0; j < 4; j++) a_mem[j] = 8'($urandom);
      d0 = a_done_cnt; base = a_en_cyc.size();
      a_start_pulse(acc);
      a_wait_done(d0, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL read_timeout: got no done expected done"); continue; end
      n_cmp++; if (a_cmd !== 24'h030000) begin n_err++; $display("FAIL read_mosi: got %h expected 030000", a_cmd); end
      n_cmp++; if (a_en_cyc.size() - base != LA + 1) begin
        n_err++; $display("FAIL read_en_count: got %0d expected %0d", a_en_cyc.size() - base, LA + 1); end
      for (int k = 0; k <= LA && base + k < a_en_cyc.size(); k++) begin
        exp_dff = (k == 0) ? 8'h00 : a_mem[k-1];
        n_cmp++;
        if (a_en_adr[base+k] !== 15'(k) || a_en_data[base+k] !== a_mem[k] || a_en_dff[base+k] !== exp_dff
            || a_en_cyc[base+k] != acc + DA * (63 + 16 * k)) begin
          n_err++; $display("FAIL read_strobe%0d: got adr %0d data %h dff %h at +%0d expected adr %0d data %h dff %h at +%0d",
            k, a_en_adr[base+k], a_en_data[base+k], a_en_dff[base+k], a_en_cyc[base+k] - acc,
            k, a_mem[k], exp_dff, DA * (63 + 16 * k));
        end
      end
      n_cmp++; if (a_done_cyc != acc + DA * (65 + 16 * LA) || a_busy !== 1'b1) begin
        n_err++; $display("FAIL read_done: got +%0d busy %b expected +%0d busy 1", a_done_cyc - acc, a_busy, DA * (65 + 16 * LA)); end
      @(negedge clk);
      n_cmp++; if ({a_busy, a_done, a_cs_n} !== 3'b001 || a_data !== a_mem[LA] || a_dff !== a_mem[LA-1] || a_adr !== 15'(LA)) begin
        n_err++; $display("FAIL read_hold: got busy/done/cs %b data %h dff %h adr %0d expected 001 %h %h %0d",
          {a_busy, a_done, a_cs_n}, a_data, a_dff, a_adr, a_mem[LA], a_mem[LA-1], LA); end
    end
  endtask

  task automatic test_start_ignored();
    int acc, d0, base; bit ok;
    for (int j = 0; j < 4; j++) a_mem[j] = 8'($urandom);
    d0 = a_done_cnt; base = a_en_cyc.size();
    a_start_pulse(acc);
    for (int i = 0; i < 1000 && a_en_cyc.size() == base; i++) @(negedge clk);
    repeat (2) begin
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      repeat (5) @(negedge clk);
    end
    a_wait_done(d0, ok);
    repeat (300) @(negedge clk);
    n_cmp++; if (!ok || a_done_cnt - d0 != 1) begin
      n_err++; $display("FAIL ignore_done_count: got %0d expected 1", a_done_cnt - d0); end
    n_cmp++; if (a_en_cyc.size() - base != LA + 1) begin
      n_err++; $display("FAIL ignore_en_count: got %0d expected %0d", a_en_cyc.size() - base, LA + 1); end
    for (int k = 0; k <= LA && base + k < a_en_cyc.size(); k++) begin
      n_cmp++; if (a_en_adr[base+k] !== 15'(k) || a_en_data[base+k] !== a_mem[k] || a_en_cyc[base+k] != acc + DA * (63 + 16 * k)) begin
        n_err++; $display("FAIL ignore_strobe%0d: got adr %0d data %h at +%0d expected adr %0d data %h at +%0d",
          k, a_en_adr[base+k], a_en_data[base+k], a_en_cyc[base+k] - acc, k, a_mem[k], DA * (63 + 16 * k)); end
    end
  endtask

  task automatic test_abort();
    int acc, d0, base; bit ok;
    for (int j = 0; j < 4; j++) a_mem[j] = 8'($urandom);
    d0 = a_done_cnt; base = a_en_cyc.size();
    a_start_pulse(acc);
    for (int i = 0; i < 1000 && a_en_cyc.size() - base < 2; i++) begin @(negedge clk); #1; end
    #2 rst = 1'b1;   // mid-cycle, well away from the rising clk edge
    #1;
    n_cmp++; if ({a_cs_n, a_sck, a_mosi, a_en, a_busy, a_done} !== 6'b100000) begin
      n_err++; $display("FAIL abort_ctrl: got %b expected 100000", {a_cs_n, a_sck, a_mosi, a_en, a_busy, a_done}); end
    n_cmp++; if ({a_data, a_dff, a_adr} !== 31'd0) begin
      n_err++; $display("FAIL abort_data: got %h expected 0", {a_data, a_dff, a_adr}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    n_cmp++; if (a_done_cnt != d0 || a_en_cyc.size() - base != 2 || a_cs_n !== 1'b1 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: got done %0d en %0d cs %b busy %b expected done 0 en 2 cs 1 busy 0",
        a_done_cnt - d0, a_en_cyc.size() - base, a_cs_n, a_busy); end
    for (int j = 0; j < 4; j++) a_mem[j] = 8'($urandom);
    d0 = a_done_cnt; base = a_en_cyc.size();
    a_start_pulse(acc);
    a_wait_done(d0, ok);
    n_cmp++; if (!ok || a_en_cyc.size() - base != LA + 1) begin
      n_err++; $display("FAIL abort_restart_count: got %0d expected %0d", a_en_cyc.size() - base, LA + 1); end
    else begin
      n_cmp++; if (a_en_adr[base] !== 15'd0 || a_en_dff[base] !== 8'h00 || a_en_data[base] !== a_mem[0]) begin
        n_err++; $display("FAIL abort_restart_first: got adr %0d data %h dff %h expected adr 0 data %h dff 00",
          a_en_adr[base], a_en_data[base], a_en_dff[base], a_mem[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, d0, base1, base2, done1; bit ok;
    logic [7:0] exp_dff;
    for (int j = 0; j < 4; j++) a_mem[j] = 8'($urandom);
    d0 = a_done_cnt; base1 = a_en_cyc.size();
    a_start_pulse(acc1);
    a_wait_done(d0, ok);
    done1 = a_done_cyc;
    for (int j = 0; j < 4; j++) a_mem[j] = 8'($urandom);
    d0 = a_done_cnt; base2 = a_en_cyc.size();
    a_start_pulse(acc2);
    n_cmp++; if (acc2 != done1 + 2 || {a_cs_n, a_busy} !== 2'b01 || {a_data, a_dff, a_adr} !== 31'd0) begin
      n_err++; $display("FAIL b2b_accept: got +%0d cs/busy %b data %h expected +2 01 0",
        acc2 - done1, {a_cs_n, a_busy}, {a_data, a_dff, a_adr}); end
    a_wait_done(d0, ok);
    n_cmp++; if (!ok || a_en_cyc.size() - base2 != LA + 1 || base2 - base1 != LA + 1) begin
      n_err++; $display("FAIL b2b_count: got %0d/%0d expected %0d", base2 - base1, a_en_cyc.size() - base2, LA + 1); end
    else begin
      for (int k = 0; k <= LA; k++) begin
        exp_dff = (k == 0) ? 8'h00 : a_mem[k-1];
        n_cmp++; if (a_en_cyc[base2+k] - acc2 != a_en_cyc[base1+k] - acc1 || a_en_adr[base2+k] !== 15'(k)
                     || a_en_data[base2+k] !== a_mem[k] || a_en_dff[base2+k] !== exp_dff) begin
          n_err++; $display("FAIL b2b_strobe%0d: got +%0d adr %0d data %h dff %h expected +%0d adr %0d data %h dff %h",
            k, a_en_cyc[base2+k] - acc2, a_en_adr[base2+k], a_en_data[base2+k], a_en_dff[base2+k],
            a_en_cyc[base1+k] - acc1, k, a_mem[k], exp_dff); end
      end
    end
  endtask

  task automatic test_single_byte();
    int acc, d0, base; bit ok;
    for (int t = 0; t < 3; t++) begin
      b_byte = (t == 0) ? 8'h7E : 8'($urandom);
      d0 = b_done_cnt; base = b_en_cyc.size();
      b_start_pulse(acc);
      b_wait_done(d0, ok);
      n_cmp++; if (!ok || b_en_cyc.size() - base != 1) begin
        n_err++; $display("FAIL single_count: got %0d expected 1", b_en_cyc.size() - base); continue; end
      n_cmp++; if (b_cmd !== 24'h030000) begin n_err++; $display("FAIL single_mosi: got %h expected 030000", b_cmd); end
      n_cmp++; if (b_en_adr[base] !== 15'd0 || b_en_data[base] !== b_byte || b_en_dff[base] !== 8'h00
                   || b_en_cyc[base] != acc + DB * 63) begin
        n_err++; $display("FAIL single_strobe: got adr %0d data %h dff %h at +%0d expected adr 0 data %h dff 00 at +%0d",
          b_en_adr[base], b_en_data[base], b_en_dff[base], b_en_cyc[base] - acc, b_byte, DB * 63); end
      n_cmp++; if (b_done_cyc != acc + DB * 65 || b_busy !== 1'b1) begin
        n_err++; $display("FAIL single_done: got +%0d busy %b expected +%0d busy 1", b_done_cyc - acc, b_busy, DB * 65); end
      @(negedge clk);
      n_cmp++; if (b_busy !== 1'b0 || b_data !== b_byte || b_adr !== 15'd0 || b_dff !== 8'h00) begin
        n_err++; $display("FAIL single_after: got busy %b data %h adr %0d dff %h expected busy 0 data %h adr 0 dff 00",
          b_busy, b_data, b_adr, b_dff, b_byte); end
    end
  endtask

  task automatic test_sck_timing();
    int acc, d0, base, mbad0, cbad0, nbad; bit ok;
    b_byte = 8'($urandom);
    repeat (2) @(negedge clk);
    d0 = b_done_cnt; base = b_runs.size(); mbad0 = b_mosi_bad; cbad0 = b_cs_bad;
    b_start_pulse(acc);
    b_wait_done(d0, ok);
    repeat (3) @(negedge clk);
    // 32 SCK periods, each low/high pair, plus the low gap before cs_n rises
    n_cmp++; if (!ok || b_runs.size() - base != 2 * (24 + 8 * (LB + 1)) + 1) begin
      n_err++; $display("FAIL sck_runs: got %0d expected %0d", b_runs.size() - base, 2 * (24 + 8 * (LB + 1)) + 1); end
    nbad = 0;
    for (int i = base; i < b_runs.size(); i++) if (b_runs[i] != DB) nbad++;
    n_cmp++; if (nbad != 0) begin n_err++; $display("FAIL sck_halfperiod: got %0d runs not %0d clk expected 0", nbad, DB); end
    n_cmp++; if (b_mosi_bad != mbad0) begin n_err++; $display("FAIL mosi_stable: got %0d changes with sck high expected 0", b_mosi_bad - mbad0); end
    n_cmp++; if (b_cs_bad != cbad0) begin n_err++; $display("FAIL cs_sck_low: got %0d cs edges with sck high expected 0", b_cs_bad - cbad0); end
  endtask

  initial begin
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; b_byte = 8'h00;
    for (int j = 0; j < 4; j++) a_mem[j] = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_read_pattern();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_single_byte();
    test_sck_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/eeprom_spi_reader.md
EEPROM_SPI_READER -- requirements
Module: eeprom_spi_reader

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL provide parameter LAST_ADR, default 15'h7FFF: byte index of the final byte read.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all flops on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to read the EEPROM image from byte 0.
REQ-007 busy  out  1  high from the cycle after start is accepted until the cycle after done.
REQ-008 done  out  1  one-cycle pulse when the transfer completes.
REQ-009 spi_cs_n  out  1  EEPROM chip select, active low.
REQ-010 spi_sck  out  1  SPI clock, mode 0, idle low.
REQ-011 spi_mosi  out  1  serial command/address to EEPROM, MSB first.
REQ-012 spi_miso  in  1  serial data from EEPROM, MSB first.
REQ-013 EN  out  1  one-cycle strobe: DATA/DATA_DFF/ADR valid for the calibration parser.
REQ-014 DATA  out  8  most recent received byte.
REQ-015 DATA_DFF  out  8  byte received immediately before DATA.
REQ-016 ADR  out  15  byte index of DATA.

Function
REQ-017 SHALL implement states IDLE, CMD, ADDR, READ, FINISH.
REQ-018 IDLE->CMD on start; start SHALL be ignored when busy=1.
REQ-019 On acceptance: spi_cs_n low next cycle; DATA, DATA_DFF, ADR cleared to 0.
REQ-020 CMD SHALL shift 8'h03; ADDR SHALL shift 16'h0000; 24 SCK periods total, no gap.
REQ-021 spi_mosi SHALL change only while spi_sck low; first bit valid CLK_DIV cycles before first rising SCK edge.
REQ-022 spi_miso SHALL be sampled on the clk cycle generating each rising SCK edge in READ.
REQ-023 SCK period SHALL be exactly 2*CLK_DIV clk cycles; one byte = 16*CLK_DIV cycles, continuous.
REQ-024 On the 8th sample of each byte, the next cycle: DATA<=byte, DATA_DFF<=old DATA, ADR<=byte index, EN=1 for one cycle.
REQ-025 Byte index SHALL start at 0 and increment by 1 per byte; ADR SHALL never wrap within a transfer.
REQ-026 After the byte with index LAST_ADR: READ->FINISH; SCK falls CLK_DIV cycles after the last rising edge, spi_cs_n rises CLK_DIV cycles later.
REQ-027 done SHALL pulse the same cycle spi_cs_n rises; FINISH->IDLE next cycle; busy low next cycle.
REQ-028 DATA, DATA_DFF, ADR SHALL hold their values between EN strobes and after done.
REQ-029 EN SHALL never be high in CMD, ADDR, FINISH, or IDLE.
REQ-030 LAST_ADR=0 SHALL produce exactly one EN strobe.

Reset
REQ-031 While rst=1: state IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, EN=0, busy=0, done=0, DATA=0, DATA_DFF=0, ADR=0, counters 0.
REQ-032 rst asserted mid-transfer SHALL abort immediately (cs_n high same cycle via async path); no further EN or done.
REQ-033 After rst deasserts, block SHALL wait in IDLE for a new start.

Verification
REQ-034 CLK_DIV=2, LAST_ADR=3, model bytes AA,55,12,34 -> mosi 03,00,00; EN x4, ADR 0..3, DATA AA,55,12,34, DATA_DFF 00,AA,55,12; EN strobes 32 clk apart; one done.
REQ-035 SCK check, CLK_DIV=4 -> high/low each exactly 4 clk; mosi stable across every rising edge; sck low when cs_n changes.
REQ-036 start pulsed again during READ -> ignored; EN count and ADR sequence unchanged.
REQ-037 rst asserted after 2nd EN -> cs_n=1, sck=0, all outputs 0 asynchronously; no done; new start restarts at ADR 0 with DATA_DFF 00.
REQ-038 LAST_ADR=0, byte 7E -> single EN with ADR 0, DATA 7E, DATA_DFF 00, then done, busy low one cycle later.
REQ-039 Two back-to-back transfers -> second starts with DATA_DFF 00 at ADR 0, identical strobe timing.
